// File: rtl/instruction_fetch_stage_pkg.sv
// Shared constants and helpers for the instruction fetch stage.
// Instruction words are 32 bits and always word-aligned.
package instruction_fetch_stage_pkg;

   localparam int XLEN        = 32;
   localparam int INSTR_BYTES = 4;

   localparam logic [XLEN-1:0] NOP_INSTRUCTION  = 32'h0000_0013;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // Redirect targets may carry junk in the byte-offset bits.
   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
      return addr & ~(XLEN'(INSTR_BYTES - 1));
   endfunction

endpackage

// File: rtl/instruction_fetch_stage_buffer.sv
// Small synchronous FIFO used both as the {pc,instr} fetch buffer and as the in-flight PC queue.
// The head entry is readable combinationally; a flush empties it in one cycle.
module fetch_buffer #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64,
   localparam int CNT_W = $clog2(DEPTH) + 1,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             flush,
   output logic [WIDTH-1:0] head_data,
   output logic [CNT_W-1:0] count,
   output logic             empty,
   output logic             full
);

   logic [WIDTH-1:0] entries [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty     = (count == '0);
   assign full      = (count == CNT_W'(DEPTH));
   assign do_pop    = pop && !empty;
   assign do_push   = push && (!full || do_pop);
   assign head_data = entries[rd_ptr];

   // DEPTH is a power of two, so the pointers wrap on their own.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) entries[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/instruction_fetch_stage.sv
// First pipeline stage: issues in-order I-cache requests under a credit limit, buffers returned
// words with their PCs, and drops responses that were in flight when a redirect arrived.
module instruction_fetch_stage
   import instruction_fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        icache_req,
   output logic [31:0] icache_address,
   input  logic        icache_ready,
   input  logic        icache_rsp_valid,
   input  logic [31:0] icache_rsp_data,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        stall_fetch_stage,
   output logic [31:0] instruction,
   output logic [31:0] pc_out,
   output logic        instruction_valid
);

   localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

   logic [XLEN-1:0]   fpc;
   logic [CNT_W-1:0]  outstanding;
   logic [CNT_W-1:0]  drop_cnt;
   logic              fetch_enable;
   logic [CNT_W-1:0]  buf_count;
   logic [CNT_W-1:0]  pcq_count;
   logic              buf_empty;
   logic              buf_full;
   logic              pcq_empty;
   logic              pcq_full;
   logic [CNT_W:0]    credit_sum;
   logic              accept;
   logic              rsp_take;
   logic              rsp_keep;
   logic              head_pop;
   logic [XLEN-1:0]   rsp_pc;
   logic [2*XLEN-1:0] head_entry;

   // Every buffer slot is reserved at request time, so the buffer can never overflow.
   assign credit_sum     = {1'b0, outstanding} + {1'b0, buf_count};
   assign icache_req     = fetch_enable && !branch_taken && (credit_sum < (CNT_W+1)'(BUF_DEPTH));
   assign icache_address = fpc;
   assign accept         = icache_req && icache_ready;
   assign rsp_take       = icache_rsp_valid && (outstanding != '0);
   assign rsp_keep       = rsp_take && (drop_cnt == '0) && !branch_taken;
   assign head_pop       = instruction_valid && !stall_fetch_stage;

   assign instruction_valid = !buf_empty;
   assign instruction       = instruction_valid ? head_entry[XLEN-1:0] : NOP_INSTRUCTION;
   assign pc_out            = instruction_valid ? head_entry[2*XLEN-1:XLEN] : '0;

   fetch_buffer #(.DEPTH(BUF_DEPTH), .WIDTH(2*XLEN)) data_buffer (
      .clk       (clk),
      .rst       (rst),
      .push      (rsp_keep),
      .push_data ({rsp_pc, icache_rsp_data}),
      .pop       (head_pop),
      .flush     (branch_taken),
      .head_data (head_entry),
      .count     (buf_count),
      .empty     (buf_empty),
      .full      (buf_full)
   );

   // The PC queue survives redirects: stale responses still have to pop their PC.
   fetch_buffer #(.DEPTH(BUF_DEPTH), .WIDTH(XLEN)) pc_queue (
      .clk       (clk),
      .rst       (rst),
      .push      (accept),
      .push_data (fpc),
      .pop       (rsp_take),
      .flush     (1'b0),
      .head_data (rsp_pc),
      .count     (pcq_count),
      .empty     (pcq_empty),
      .full      (pcq_full)
   );

   // A redirect reloads drop_cnt from what is still in flight after this cycle's response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fpc          <= RESET_PC;
         outstanding  <= '0;
         drop_cnt     <= '0;
         fetch_enable <= 1'b0;
      end else begin
         fetch_enable <= 1'b1;
         if (branch_taken)
            fpc <= align_pc(branch_target);
         else if (accept)
            fpc <= fpc + XLEN'(INSTR_BYTES);
         outstanding <= outstanding + CNT_W'(accept) - CNT_W'(rsp_take);
         if (branch_taken)
            drop_cnt <= outstanding - CNT_W'(rsp_take);
         else if (rsp_take && (drop_cnt != '0))
            drop_cnt <= drop_cnt - CNT_W'(1);
      end
   end

   a_rsp_needs_request: assert property (@(posedge clk) disable iff (rst)
      icache_rsp_valid |-> (outstanding != '0) && !pcq_empty);
   a_pcq_tracks_outstanding: assert property (@(posedge clk) disable iff (rst)
      pcq_count == outstanding);
   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(rsp_keep && buf_full && !head_pop) && !(accept && pcq_full));

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed vector table for the default-reset instance plus a long randomized run on a second
// instance starting near the top of the address space, checked against a queue-based model.
module tb_instruction_fetch_stage;
   import instruction_fetch_stage_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, icache_ready, icache_rsp_valid, branch_taken, stall_fetch_stage;
   logic [31:0] icache_rsp_data, branch_target;
   logic        icache_req, instruction_valid;
   logic [31:0] icache_address, instruction, pc_out;

   logic        w_rst, w_icache_ready, w_rsp_valid, w_branch, w_stall;
   logic [31:0] w_rsp_data, w_target;
   logic        w_icache_req, w_valid;
   logic [31:0] w_icache_address, w_instruction, w_pc_out;

   int checks = 0;
   int failures = 0;

   instruction_fetch_stage dut (
      .clk               (clk),
      .rst               (rst),
      .icache_req        (icache_req),
      .icache_address    (icache_address),
      .icache_ready      (icache_ready),
      .icache_rsp_valid  (icache_rsp_valid),
      .icache_rsp_data   (icache_rsp_data),
      .branch_taken      (branch_taken),
      .branch_target     (branch_target),
      .stall_fetch_stage (stall_fetch_stage),
      .instruction       (instruction),
      .pc_out            (pc_out),
      .instruction_valid (instruction_valid)
   );

   instruction_fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)) dut_wrap (
      .clk               (clk),
      .rst               (w_rst),
      .icache_req        (w_icache_req),
      .icache_address    (w_icache_address),
      .icache_ready      (w_icache_ready),
      .icache_rsp_valid  (w_rsp_valid),
      .icache_rsp_data   (w_rsp_data),
      .branch_taken      (w_branch),
      .branch_target     (w_target),
      .stall_fetch_stage (w_stall),
      .instruction       (w_instruction),
      .pc_out            (w_pc_out),
      .instruction_valid (w_valid)
   );

   typedef struct {
      logic        ready;
      logic        rsp_valid;
      logic [31:0] rsp_pc;
      logic        branch;
      logic [31:0] target;
      logic        stall;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_valid;
      logic [31:0] exp_pc;
   } vec_t;

   vec_t vecs[26];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hDEAD_0000;
   endfunction

   function automatic vec_t make_vec(input logic rdy, input logic rv, input logic [31:0] rpc,
                                     input logic br, input logic [31:0] tgt, input logic st,
                                     input logic er, input logic [31:0] ea, input logic ev,
                                     input logic [31:0] epc);
      vec_t v;
      v.ready = rdy; v.rsp_valid = rv; v.rsp_pc = rpc; v.branch = br; v.target = tgt;
      v.stall = st; v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_pc = epc;
      return v;
   endfunction

   task automatic applyStimulus(input vec_t v);
      icache_ready      = v.ready;
      icache_rsp_valid  = v.rsp_valid;
      icache_rsp_data   = v.rsp_valid ? mem_word(v.rsp_pc) : 32'h0BAD_0BAD;
      branch_taken      = v.branch;
      branch_target     = v.target;
      stall_fetch_stage = v.stall;
   endtask

   task automatic checkOutput(input string name,
                              input logic a_req, input logic [31:0] a_addr, input logic a_valid,
                              input logic [31:0] a_pc, input logic [31:0] a_instr,
                              input logic e_req, input logic [31:0] e_addr, input logic e_valid,
                              input logic [31:0] e_pc, input logic [31:0] e_instr);
      checks++;
      if ({a_req, a_addr, a_valid, a_pc, a_instr} !== {e_req, e_addr, e_valid, e_pc, e_instr}) begin
         failures++;
         $display("[TB] FAIL %s: got req=%b addr=%h valid=%b pc=%h instr=%h, expected req=%b addr=%h valid=%b pc=%h instr=%h",
                  name, a_req, a_addr, a_valid, a_pc, a_instr, e_req, e_addr, e_valid, e_pc, e_instr);
      end
   endtask

   task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic check_main(input string name, input logic e_req, input logic [31:0] e_addr,
                             input logic e_valid, input logic [31:0] e_pc);
      checkOutput(name, icache_req, icache_address, instruction_valid, pc_out, instruction,
                  e_req, e_addr, e_valid, e_pc, e_valid ? mem_word(e_pc) : NOP_INSTRUCTION);
   endtask

   // Randomized run on the wrap instance; the model keeps plain queues of in-flight PCs and
   // buffered {pc,instr} entries, and the cache answers in order after 1..4 cycles.
   task automatic run_random(input int cycles);
      logic [31:0] m_fpc;
      int          m_drop;
      logic [31:0] pend[$];
      logic [63:0] mbuf[$];
      logic [31:0] cq_addr[$];
      int          cq_due[$];
      int          last_due;
      int          due;
      int          ncap;
      logic [31:0] caps[3];
      logic        m_req;
      logic        keep;
      logic [31:0] rsp_pc;

      m_fpc = 32'hFFFF_FFF8; m_drop = 0; last_due = -1; ncap = 0;
      @(negedge clk);
      w_rst = 1'b0;
      #1;
      checkOutput("wrap_first_cycle", w_icache_req, w_icache_address, w_valid, w_pc_out, w_instruction,
                  1'b0, 32'hFFFF_FFF8, 1'b0, 32'h0, NOP_INSTRUCTION);

      for (int cyc = 0; cyc < cycles; cyc++) begin
         @(negedge clk);
         w_icache_ready = ($urandom_range(0, 3) != 0);
         w_stall        = ($urandom_range(0, 3) == 0);
         w_branch       = (ncap >= 3) && ($urandom_range(0, 23) == 0);
         w_target       = ($urandom_range(0, 1) == 1) ? $urandom
                                                       : (32'hFFFF_FFE0 + 32'($urandom_range(0, 31)));
         w_rsp_valid    = (cq_addr.size() > 0) && (cq_due[0] <= cyc);
         w_rsp_data     = w_rsp_valid ? mem_word(cq_addr[0]) : $urandom;
         #1;
         m_req = !w_branch && ((pend.size() + mbuf.size()) < 2);
         checkOutput($sformatf("rand[%0d]", cyc), w_icache_req, w_icache_address, w_valid, w_pc_out,
                     w_instruction, m_req, m_fpc, mbuf.size() > 0,
                     (mbuf.size() > 0) ? mbuf[0][63:32] : 32'h0,
                     (mbuf.size() > 0) ? mbuf[0][31:0] : NOP_INSTRUCTION);

         if (w_icache_req && w_icache_ready && ncap < 3) begin
            caps[ncap] = w_icache_address;
            ncap++;
         end
         if (w_rsp_valid) begin
            void'(cq_addr.pop_front());
            void'(cq_due.pop_front());
         end
         if (w_icache_req && w_icache_ready) begin
            due = cyc + int'($urandom_range(1, 4));
            if (due <= last_due) due = last_due + 1;
            cq_addr.push_back(w_icache_address);
            cq_due.push_back(due);
            last_due = due;
         end

         keep = 1'b0;
         rsp_pc = 32'h0;
         if (w_rsp_valid) begin
            if (pend.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL model_pend_underflow: got response at cycle %0d, expected none in flight", cyc);
            end else begin
               rsp_pc = pend.pop_front();
               if (m_drop > 0) m_drop--;
               else keep = !w_branch;
            end
         end
         if (w_branch) begin
            mbuf.delete();
            m_drop = pend.size();
            m_fpc  = w_target & 32'hFFFF_FFFC;
         end else begin
            if (mbuf.size() > 0 && !w_stall) void'(mbuf.pop_front());
            if (keep) mbuf.push_back({rsp_pc, w_rsp_data});
            if (m_req && w_icache_ready) begin
               pend.push_back(m_fpc);
               m_fpc = m_fpc + 32'd4;
            end
         end
      end

      check_word("wrap_count", 32'(ncap), 32'd3);
      check_word("wrap_fetch0", caps[0], 32'hFFFF_FFF8);
      check_word("wrap_fetch1", caps[1], 32'hFFFF_FFFC);
      check_word("wrap_fetch2", caps[2], 32'h0000_0000);
   endtask

   initial begin
      // Streaming, 5-cycle stall, redirect with two in flight, redirect+response under stall.
      vecs[0]  = make_vec(1, 0, 32'h000, 0, 32'h000, 0,  1, 32'h000, 0, 32'h000);
      vecs[1]  = make_vec(1, 1, 32'h000, 0, 32'h000, 0,  1, 32'h004, 0, 32'h000);
      vecs[2]  = make_vec(1, 1, 32'h004, 0, 32'h000, 0,  0, 32'h008, 1, 32'h000);
      vecs[3]  = make_vec(1, 0, 32'h000, 0, 32'h000, 0,  1, 32'h008, 1, 32'h004);
      vecs[4]  = make_vec(1, 1, 32'h008, 0, 32'h000, 0,  1, 32'h00C, 0, 32'h000);
      vecs[5]  = make_vec(1, 1, 32'h00C, 0, 32'h000, 0,  0, 32'h010, 1, 32'h008);
      vecs[6]  = make_vec(1, 0, 32'h000, 0, 32'h000, 1,  1, 32'h010, 1, 32'h00C);
      vecs[7]  = make_vec(1, 1, 32'h010, 0, 32'h000, 1,  0, 32'h014, 1, 32'h00C);
      vecs[8]  = make_vec(1, 0, 32'h000, 0, 32'h000, 1,  0, 32'h014, 1, 32'h00C);
      vecs[9]  = make_vec(1, 0, 32'h000, 0, 32'h000, 1,  0, 32'h014, 1, 32'h00C);
      vecs[10] = make_vec(1, 0, 32'h000, 0, 32'h000, 1,  0, 32'h014, 1, 32'h00C);
      vecs[11] = make_vec(1, 0, 32'h000, 0, 32'h000, 0,  0, 32'h014, 1, 32'h00C);
      vecs[12] = make_vec(1, 0, 32'h000, 0, 32'h000, 0,  1, 32'h014, 1, 32'h010);
      vecs[13] = make_vec(1, 0, 32'h000, 0, 32'h000, 0,  1, 32'h018, 0, 32'h000);
      vecs[14] = make_vec(1, 0, 32'h000, 1, 32'h103, 0,  0, 32'h01C, 0, 32'h000);
      vecs[15] = make_vec(1, 1, 32'h014, 0, 32'h000, 0,  0, 32'h100, 0, 32'h000);
      vecs[16] = make_vec(1, 1, 32'h018, 0, 32'h000, 0,  1, 32'h100, 0, 32'h000);
      vecs[17] = make_vec(1, 1, 32'h100, 0, 32'h000, 0,  1, 32'h104, 0, 32'h000);
      vecs[18] = make_vec(1, 0, 32'h000, 0, 32'h000, 0,  0, 32'h108, 1, 32'h100);
      vecs[19] = make_vec(1, 0, 32'h000, 0, 32'h000, 0,  1, 32'h108, 0, 32'h000);
      vecs[20] = make_vec(1, 1, 32'h104, 1, 32'h200, 1,  0, 32'h10C, 0, 32'h000);
      vecs[21] = make_vec(1, 1, 32'h108, 0, 32'h000, 1,  1, 32'h200, 0, 32'h000);
      vecs[22] = make_vec(1, 1, 32'h200, 0, 32'h000, 0,  1, 32'h204, 0, 32'h000);
      vecs[23] = make_vec(1, 0, 32'h000, 0, 32'h000, 0,  0, 32'h208, 1, 32'h200);
      vecs[24] = make_vec(0, 1, 32'h204, 0, 32'h000, 0,  1, 32'h208, 0, 32'h000);
      vecs[25] = make_vec(1, 0, 32'h000, 0, 32'h000, 0,  1, 32'h208, 1, 32'h204);

      rst = 1'b1; icache_ready = 1'b0; icache_rsp_valid = 1'b0; icache_rsp_data = '0;
      branch_taken = 1'b0; branch_target = '0; stall_fetch_stage = 1'b0;
      w_rst = 1'b1; w_icache_ready = 1'b0; w_rsp_valid = 1'b0; w_rsp_data = '0;
      w_branch = 1'b0; w_target = '0; w_stall = 1'b0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      check_main("reset_hold", 1'b0, 32'h0, 1'b0, 32'h0);
      rst = 1'b0;
      #1;
      check_main("first_cycle_no_req", 1'b0, 32'h0, 1'b0, 32'h0);

      for (int i = 0; i < 26; i++) begin
         @(negedge clk);
         applyStimulus(vecs[i]);
         #1;
         check_main($sformatf("vec[%0d]", i), vecs[i].exp_req, vecs[i].exp_addr,
                    vecs[i].exp_valid, vecs[i].exp_pc);
      end

      // Asynchronous reset mid-run, with a request in flight and fpc far from zero.
      @(posedge clk);
      icache_ready = 1'b0; icache_rsp_valid = 1'b0; branch_taken = 1'b0; stall_fetch_stage = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check_main("async_reset", 1'b0, 32'h0, 1'b0, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_main("release_cycle", 1'b0, 32'h0, 1'b0, 32'h0);
      @(negedge clk);
      #1;
      check_main("after_release", 1'b1, 32'h0, 1'b0, 32'h0);

      run_random(10000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
